// File: rtl/unified_store_router.sv
// unified_store_router
// Write-back router between the shared FFT/NTT butterfly and the two result
// BRAM banks. Each lane's issue token (bank, addr, mode) travels through a
// per-lane timing wheel. The slot index is "cycles until exit", and a token is
// inserted at slot L-1, where L is chosen by the token's own mode tag. When the
// token reaches slot 0, the lane's butterfly output is sampled. That word is
// then either written to its bank on the next edge or deferred to a small FIFO
// when it loses bank arbitration.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   iss_valid_a/b, iss_bank_a/b     token issue per lane, destination bank
//   iss_addr_a/b                    destination address per lane
//   iss_is_fft, iss_is_dif          mode tag shared by both lanes at issue
//   a_wide, b_wide                  butterfly FFT/NTT0 words
//   a_rns, b_rns                    RNS residues, channel k at [k*LOGQ +: LOGQ]
//   wr_en_0/1, wr_addr_0/1          registered bank write port
//   wr_wide_0/1, wr_rns_0/1         registered bank write data
//   clr_status                      synchronous clear of sticky flags
//   busy                            token in flight or deferred write pending
//   defer_ovf                       sticky: a deferred write was dropped
//   lane_clash                      sticky: two tokens of one lane exited together
//
// Handshake: issue is valid-only. A token is accepted on every edge where
// iss_valid_x is high. There is no ready and no backpressure. The bank write
// port is likewise valid-only, and the BRAM takes wr_en_x unconditionally.

`ifndef OVERALL_BITS
`define OVERALL_BITS 32
`endif
`ifndef DELAY_FLP_ADDER
`define DELAY_FLP_ADDER 3
`endif
`ifndef DELAY_COMPLEX_MULT
`define DELAY_COMPLEX_MULT 6
`endif

module unified_store_router #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WIDE_WIDTH  = 2*`OVERALL_BITS,
  parameter int LOGQ        = 54,
  parameter int NUM_RNS     = 2,
  parameter int LAT_A_FFT   = `DELAY_FLP_ADDER,
  parameter int LAT_A_DIF   = 4,
  parameter int LAT_A_DIT   = 1,
  parameter int LAT_B_FDIF  = `DELAY_FLP_ADDER + `DELAY_COMPLEX_MULT + 2,
  parameter int LAT_B_FDIT  = LAT_B_FDIF + 1,
  parameter int LAT_B_DIF   = 20,
  parameter int LAT_B_DIT   = 18,
  parameter int DEFER_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iss_valid_a,
  input  logic                       iss_valid_b,
  input  logic                       iss_bank_a,
  input  logic                       iss_bank_b,
  input  logic [ADDR_WIDTH-1:0]      iss_addr_a,
  input  logic [ADDR_WIDTH-1:0]      iss_addr_b,
  input  logic                       iss_is_fft,
  input  logic                       iss_is_dif,
  input  logic [WIDE_WIDTH-1:0]      a_wide,
  input  logic [WIDE_WIDTH-1:0]      b_wide,
  input  logic [NUM_RNS*LOGQ-1:0]    a_rns,
  input  logic [NUM_RNS*LOGQ-1:0]    b_rns,
  output logic                       wr_en_0,
  output logic                       wr_en_1,
  output logic [ADDR_WIDTH-1:0]      wr_addr_0,
  output logic [ADDR_WIDTH-1:0]      wr_addr_1,
  output logic [WIDE_WIDTH-1:0]      wr_wide_0,
  output logic [WIDE_WIDTH-1:0]      wr_wide_1,
  output logic [NUM_RNS*LOGQ-1:0]    wr_rns_0,
  output logic [NUM_RNS*LOGQ-1:0]    wr_rns_1,
  input  logic                       clr_status,
  output logic                       busy,
  output logic                       defer_ovf,
  output logic                       lane_clash
);

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  localparam int RW = NUM_RNS * LOGQ;
  localparam int DL = imax(imax(imax(LAT_A_FFT, LAT_A_DIF), imax(LAT_A_DIT, LAT_B_FDIF)),
                           imax(imax(LAT_B_FDIT, LAT_B_DIF), LAT_B_DIT));
  localparam int PW = $clog2(DEFER_DEPTH);

  // Per-lane timing wheel; index 0 is the exit slot.
  logic                  slot_v     [2][DL];
  logic                  slot_clash [2][DL];
  logic                  slot_bank  [2][DL];
  logic [ADDR_WIDTH-1:0] slot_addr  [2][DL];
  logic                  nxt_v      [2][DL];
  logic                  nxt_clash  [2][DL];
  logic                  nxt_bank   [2][DL];
  logic [ADDR_WIDTH-1:0] nxt_addr   [2][DL];

  logic [1:0]            iss_v, iss_bk;
  logic [ADDR_WIDTH-1:0] iss_ad [2];
  int                    lat    [2];

  assign iss_v     = {iss_valid_b, iss_valid_a};
  assign iss_bk    = {iss_bank_b, iss_bank_a};
  assign iss_ad[0] = iss_addr_a;
  assign iss_ad[1] = iss_addr_b;

  always_comb begin
    lat[0] = iss_is_fft ? LAT_A_FFT : (iss_is_dif ? LAT_A_DIF : LAT_A_DIT);
    lat[1] = iss_is_fft ? (iss_is_dif ? LAT_B_FDIF : LAT_B_FDIT)
                        : (iss_is_dif ? LAT_B_DIF : LAT_B_DIT);
  end

  // Advance the wheel by one slot, then drop the new token into slot L-1.
  // If an older token already lands in that slot, the older token keeps it
  // and the younger token is merged away. The clash bit raises lane_clash
  // when the older token exits.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < DL-1; i++) begin
        nxt_v[l][i]     = slot_v[l][i+1];
        nxt_clash[l][i] = slot_clash[l][i+1];
        nxt_bank[l][i]  = slot_bank[l][i+1];
        nxt_addr[l][i]  = slot_addr[l][i+1];
      end
      nxt_v[l][DL-1]     = 1'b0;
      nxt_clash[l][DL-1] = 1'b0;
      nxt_bank[l][DL-1]  = 1'b0;
      nxt_addr[l][DL-1]  = '0;
      for (int i = 0; i < DL; i++) begin
        if (iss_v[l] && (i == lat[l] - 1)) begin
          if (nxt_v[l][i]) begin
            nxt_clash[l][i] = 1'b1;
          end else begin
            nxt_v[l][i]     = 1'b1;
            nxt_clash[l][i] = 1'b0;
            nxt_bank[l][i]  = iss_bk[l];
            nxt_addr[l][i]  = iss_ad[l];
          end
        end
      end
    end
  end

  // Deferral FIFO: the extra pointer bit separates full from empty.
  logic                  fifo_bank [DEFER_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [DEFER_DEPTH];
  logic [WIDE_WIDTH-1:0] fifo_wide [DEFER_DEPTH];
  logic [RW-1:0]         fifo_rns  [DEFER_DEPTH];
  logic [PW:0]           rptr, wptr, count;
  logic                  fifo_empty;
  logic [PW-1:0]         head_idx, widx_b;

  assign count      = wptr - rptr;
  assign fifo_empty = (count == '0);
  assign head_idx   = rptr[PW-1:0];

  // Arbitration candidates: 0 = FIFO head, 1 = lane A exit, 2 = lane B exit.
  logic [2:0]            cand_v, cand_bank;
  logic [ADDR_WIDTH-1:0] cand_addr [3];
  logic [WIDE_WIDTH-1:0] cand_wide [3];
  logic [RW-1:0]         cand_rns  [3];

  assign cand_v       = {slot_v[1][0], slot_v[0][0], !fifo_empty};
  assign cand_bank    = {slot_bank[1][0], slot_bank[0][0], fifo_bank[head_idx]};
  assign cand_addr[0] = fifo_addr[head_idx];
  assign cand_addr[1] = slot_addr[0][0];
  assign cand_addr[2] = slot_addr[1][0];
  assign cand_wide[0] = fifo_wide[head_idx];
  assign cand_wide[1] = a_wide;
  assign cand_wide[2] = b_wide;
  assign cand_rns[0]  = fifo_rns[head_idx];
  assign cand_rns[1]  = a_rns;
  assign cand_rns[2]  = b_rns;

  logic                  sel_v    [2];
  logic [ADDR_WIDTH-1:0] sel_addr [2];
  logic [WIDE_WIDTH-1:0] sel_wide [2];
  logic [RW-1:0]         sel_rns  [2];

  // Scan from lowest to highest priority so the highest-priority match wins.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      sel_v[k]    = 1'b0;
      sel_addr[k] = '0;
      sel_wide[k] = '0;
      sel_rns[k]  = '0;
      for (int c = 2; c >= 0; c--) begin
        if (cand_v[c] && (cand_bank[c] == k[0])) begin
          sel_v[k]    = 1'b1;
          sel_addr[k] = cand_addr[c];
          sel_wide[k] = cand_wide[c];
          sel_rns[k]  = cand_rns[c];
        end
      end
    end
  end

  logic lose_a, lose_b, acc_a, acc_b, drop, clash_exit;
  int   free_slots;

  // The head is always popped when present. Its slot is reusable this cycle.
  assign lose_a = cand_v[1] & cand_v[0] & (cand_bank[1] == cand_bank[0]);
  assign lose_b = cand_v[2] & ((cand_v[0] & (cand_bank[2] == cand_bank[0])) |
                               (cand_v[1] & (cand_bank[2] == cand_bank[1])));
  assign clash_exit = (slot_v[0][0] & slot_clash[0][0]) | (slot_v[1][0] & slot_clash[1][0]);

  always_comb begin
    free_slots = DEFER_DEPTH - int'(count) + (fifo_empty ? 0 : 1);
    acc_a      = lose_a && (free_slots >= 1);
    acc_b      = lose_b && (free_slots >= (acc_a ? 2 : 1));
    drop       = (lose_a && !acc_a) || (lose_b && !acc_b);
  end

  assign widx_b = acc_a ? (wptr[PW-1:0] + PW'(1)) : wptr[PW-1:0];

  always_ff @(posedge clk) begin
    if (acc_a) begin
      fifo_bank[wptr[PW-1:0]] <= cand_bank[1];
      fifo_addr[wptr[PW-1:0]] <= cand_addr[1];
      fifo_wide[wptr[PW-1:0]] <= cand_wide[1];
      fifo_rns[wptr[PW-1:0]]  <= cand_rns[1];
    end
    if (acc_b) begin
      fifo_bank[widx_b] <= cand_bank[2];
      fifo_addr[widx_b] <= cand_addr[2];
      fifo_wide[widx_b] <= cand_wide[2];
      fifo_rns[widx_b]  <= cand_rns[2];
    end
  end

  logic                  out_en   [2];
  logic [ADDR_WIDTH-1:0] out_addr [2];
  logic [WIDE_WIDTH-1:0] out_wide [2];
  logic [RW-1:0]         out_rns  [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        for (int i = 0; i < DL; i++) begin
          slot_v[l][i]     <= 1'b0;
          slot_clash[l][i] <= 1'b0;
          slot_bank[l][i]  <= 1'b0;
          slot_addr[l][i]  <= '0;
        end
        out_en[l]   <= 1'b0;
        out_addr[l] <= '0;
        out_wide[l] <= '0;
        out_rns[l]  <= '0;
      end
      rptr       <= '0;
      wptr       <= '0;
      defer_ovf  <= 1'b0;
      lane_clash <= 1'b0;
    end else begin
      slot_v     <= nxt_v;
      slot_clash <= nxt_clash;
      slot_bank  <= nxt_bank;
      slot_addr  <= nxt_addr;
      for (int k = 0; k < 2; k++) begin
        out_en[k]   <= sel_v[k];
        out_addr[k] <= sel_addr[k];
        out_wide[k] <= sel_wide[k];
        out_rns[k]  <= sel_rns[k];
      end
      if (!fifo_empty) rptr <= rptr + (PW+1)'(1);
      wptr       <= wptr + (PW+1)'(acc_a) + (PW+1)'(acc_b);
      // A new event on the same edge as clr_status keeps the flag set.
      defer_ovf  <= drop | (defer_ovf & ~clr_status);
      lane_clash <= clash_exit | (lane_clash & ~clr_status);
    end
  end

  always_comb begin
    busy = !fifo_empty;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < DL; i++) busy = busy | slot_v[l][i];
    end
  end

  assign wr_en_0   = out_en[0];
  assign wr_en_1   = out_en[1];
  assign wr_addr_0 = out_addr[0];
  assign wr_addr_1 = out_addr[1];
  assign wr_wide_0 = out_wide[0];
  assign wr_wide_1 = out_wide[1];
  assign wr_rns_0  = out_rns[0];
  assign wr_rns_1  = out_rns[1];

endmodule

// File: tb/tb_unified_store_router.sv
`timescale 1ns/1ps
module tb_unified_store_router;

  localparam int AW = 12, WW = 64, LOGQ = 54, NR = 2, RW = NR*LOGQ, DEPTH = 4;
  localparam int L_A_FFT = 3, L_A_DIF = 4, L_A_DIT = 1;
  localparam int L_B_FDIF = 11, L_B_FDIT = 12, L_B_DIF = 20, L_B_DIT = 18;
  localparam int EW = 1 + AW + WW + RW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          iss_valid_a = 0, iss_valid_b = 0, iss_bank_a = 0, iss_bank_b = 0;
  logic [AW-1:0] iss_addr_a = '0, iss_addr_b = '0;
  logic          iss_is_fft = 0, iss_is_dif = 0, clr_status = 0;
  logic [WW-1:0] a_wide = '0, b_wide = '0;
  logic [RW-1:0] a_rns = '0, b_rns = '0;
  logic          wr_en_0, wr_en_1, busy, defer_ovf, lane_clash;
  logic [AW-1:0] wr_addr_0, wr_addr_1;
  logic [WW-1:0] wr_wide_0, wr_wide_1;
  logic [RW-1:0] wr_rns_0, wr_rns_1;

  unified_store_router #(
    .ADDR_WIDTH(AW), .WIDE_WIDTH(WW), .LOGQ(LOGQ), .NUM_RNS(NR),
    .LAT_A_FFT(L_A_FFT), .LAT_A_DIF(L_A_DIF), .LAT_A_DIT(L_A_DIT),
    .LAT_B_FDIF(L_B_FDIF), .LAT_B_FDIT(L_B_FDIT), .LAT_B_DIF(L_B_DIF),
    .LAT_B_DIT(L_B_DIT), .DEFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid_a(iss_valid_a), .iss_valid_b(iss_valid_b),
    .iss_bank_a(iss_bank_a), .iss_bank_b(iss_bank_b),
    .iss_addr_a(iss_addr_a), .iss_addr_b(iss_addr_b),
    .iss_is_fft(iss_is_fft), .iss_is_dif(iss_is_dif),
    .a_wide(a_wide), .b_wide(b_wide), .a_rns(a_rns), .b_rns(b_rns),
    .wr_en_0(wr_en_0), .wr_en_1(wr_en_1),
    .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
    .wr_wide_0(wr_wide_0), .wr_wide_1(wr_wide_1),
    .wr_rns_0(wr_rns_0), .wr_rns_1(wr_rns_1),
    .clr_status(clr_status), .busy(busy),
    .defer_ovf(defer_ovf), .lane_clash(lane_clash)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            lane;
    int            exit_c;
    logic          bank;
    logic [AW-1:0] addr;
  } tok_t;

  tok_t          toks[$];
  tok_t          keep[$];
  tok_t          t_new;
  logic [EW-1:0] exp_q[$];      // deferred writes still owed to a bank, oldest first
  logic [EW-1:0] losers[$];
  logic [EW-1:0] cand_e[3];
  logic [2:0]    cand_v;
  logic [EW-1:0] m_ent[2];
  logic [1:0]    m_en = '0;
  logic          m_busy = 0, m_ovf = 0, m_clash = 0, drop_evt, clash_evt;
  int            mcyc = 0;
  int            n_exit[2];

  function automatic int lat_of(input int lane, input logic fft, input logic dif);
    if (lane == 0) return fft ? L_A_FFT : (dif ? L_A_DIF : L_A_DIT);
    return fft ? (dif ? L_B_FDIF : L_B_FDIT) : (dif ? L_B_DIF : L_B_DIT);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toks.delete(); exp_q.delete();
      m_en = '0; m_busy = 0; m_ovf = 0; m_clash = 0;
      m_ent[0] = '0; m_ent[1] = '0;
    end else begin
      drop_evt = 0; cand_v = '0; n_exit[0] = 0; n_exit[1] = 0;
      if (exp_q.size() > 0) begin cand_v[0] = 1; cand_e[0] = exp_q[0]; end
      keep.delete();
      foreach (toks[i]) begin
        if (toks[i].exit_c == mcyc) begin
          if (n_exit[toks[i].lane] == 0) begin
            cand_v[toks[i].lane + 1] = 1;
            if (toks[i].lane == 0) cand_e[1] = {toks[i].bank, toks[i].addr, a_wide, a_rns};
            else                   cand_e[2] = {toks[i].bank, toks[i].addr, b_wide, b_rns};
          end
          n_exit[toks[i].lane]++;
        end else keep.push_back(toks[i]);
      end
      clash_evt = (n_exit[0] > 1) || (n_exit[1] > 1);
      toks = keep;
      if (iss_valid_a) begin
        t_new.lane = 0; t_new.exit_c = mcyc + lat_of(0, iss_is_fft, iss_is_dif);
        t_new.bank = iss_bank_a; t_new.addr = iss_addr_a; toks.push_back(t_new);
      end
      if (iss_valid_b) begin
        t_new.lane = 1; t_new.exit_c = mcyc + lat_of(1, iss_is_fft, iss_is_dif);
        t_new.bank = iss_bank_b; t_new.addr = iss_addr_b; toks.push_back(t_new);
      end
      m_en = '0; losers.delete();
      for (int c = 0; c < 3; c++) begin
        if (cand_v[c]) begin
          if (!m_en[cand_e[c][EW-1]]) begin
            m_en[cand_e[c][EW-1]] = 1;
            m_ent[cand_e[c][EW-1]] = cand_e[c];
          end else losers.push_back(cand_e[c]);
        end
      end
      if (cand_v[0]) void'(exp_q.pop_front());
      foreach (losers[i]) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(losers[i]);
        else drop_evt = 1;
      end
      m_ovf   = drop_evt  | (m_ovf   & ~clr_status);
      m_clash = clash_evt | (m_clash & ~clr_status);
      m_busy  = (toks.size() > 0) || (exp_q.size() > 0);
      mcyc++;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("cmp_wr_en_0", wr_en_0, m_en[0]);
    chk("cmp_wr_en_1", wr_en_1, m_en[1]);
    if (m_en[0]) begin
      chk("cmp_wr_addr_0", wr_addr_0, m_ent[0][EW-2 -: AW]);
      chk("cmp_wr_wide_0", wr_wide_0, m_ent[0][RW +: WW]);
      chk("cmp_wr_rns_0",  wr_rns_0,  m_ent[0][RW-1:0]);
    end
    if (m_en[1]) begin
      chk("cmp_wr_addr_1", wr_addr_1, m_ent[1][EW-2 -: AW]);
      chk("cmp_wr_wide_1", wr_wide_1, m_ent[1][RW +: WW]);
      chk("cmp_wr_rns_1",  wr_rns_1,  m_ent[1][RW-1:0]);
    end
    chk("cmp_busy", busy, m_busy);
    chk("cmp_defer_ovf", defer_ovf, m_ovf);
    chk("cmp_lane_clash", lane_clash, m_clash);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_issue();
    iss_valid_a = 0; iss_valid_b = 0; clr_status = 0;
  endtask

  task automatic set_mode(input logic fft, input logic dif);
    iss_is_fft = fft; iss_is_dif = dif;
  endtask

  task automatic issue_a(input logic bank, input int addr);
    iss_valid_a = 1; iss_bank_a = bank; iss_addr_a = AW'(addr);
  endtask

  task automatic issue_b(input logic bank, input int addr);
    iss_valid_b = 1; iss_bank_b = bank; iss_addr_b = AW'(addr);
  endtask

  task automatic rand_data();
    logic [127:0] r;
    a_wide = {$urandom(), $urandom()};
    b_wide = {$urandom(), $urandom()};
    r = {$urandom(), $urandom(), $urandom(), $urandom()}; a_rns = r[RW-1:0];
    r = {$urandom(), $urandom(), $urandom(), $urandom()}; b_rns = r[RW-1:0];
  endtask

  // FFT lane-B token to bank 1 addr 3; the write must land exactly lat+1 after issue.
  task automatic run_b_fft(input logic dif, input int lat, input string tag);
    logic [WW-1:0] d;
    set_mode(1, dif); issue_b(1, 3);
    tick(); idle_issue();
    repeat (lat - 1) tick();
    chk({tag, "_early"}, wr_en_1, 1'b0);
    d = {$urandom(), $urandom()}; b_wide = d;
    tick();
    chk({tag, "_en"}, wr_en_1, 1'b1);
    chk({tag, "_addr"}, wr_addr_1, 3);
    chk({tag, "_data"}, wr_wide_1, d);
    tick();
  endtask

  int            seq4[10] = '{16, 32, 17, 33, 18, 34, 19, 35, 20, 21};
  logic [WW-1:0] da, db;
  logic [RW-1:0] ra;
  int            wcount;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en_0", wr_en_0, 1'b0);
    chk("reset_wr_en_1", wr_en_1, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_flags", {defer_ovf, lane_clash}, 2'b00);
    rst_n = 1;
    repeat (2) tick();

    // 1: NTT DIT, A->bank0 addr5 and B->bank1 addr9 issued together
    set_mode(0, 0); issue_a(0, 5); issue_b(1, 9);
    tick(); idle_issue();
    da = 64'h1111_2222_3333_4444; ra = {$urandom(), $urandom(), $urandom(), $urandom()};
    a_wide = da; a_rns = ra;
    tick();
    chk("t1_a_en", wr_en_0, 1'b1);
    chk("t1_a_addr", wr_addr_0, 5);
    chk("t1_a_data", wr_wide_0, da);
    chk("t1_a_rns", wr_rns_0, ra);
    chk("t1_a_other", wr_en_1, 1'b0);
    repeat (16) tick();
    chk("t1_b_early", wr_en_1, 1'b0);
    db = 64'hAAAA_BBBB_CCCC_DDDD; b_wide = db;
    tick();
    chk("t1_b_en", wr_en_1, 1'b1);
    chk("t1_b_addr", wr_addr_1, 9);
    chk("t1_b_data", wr_wide_1, db);
    chk("t1_b_other", wr_en_0, 1'b0);
    repeat (3) tick();

    // 2: FFT DIF vs DIT on lane B
    run_b_fft(1, L_B_FDIF, "t2_dif");
    run_b_fft(0, L_B_FDIT, "t2_dit");

    // 3: A and B exit to bank 0 in the same cycle
    set_mode(0, 0); issue_b(0, 2);
    tick(); idle_issue();
    repeat (16) tick();
    issue_a(0, 1);
    tick(); idle_issue();
    da = {$urandom(), $urandom()}; db = {$urandom(), $urandom()};
    a_wide = da; b_wide = db;
    tick();
    chk("t3_first_en", wr_en_0, 1'b1);
    chk("t3_first_addr", wr_addr_0, 1);
    chk("t3_first_data", wr_wide_0, da);
    chk("t3_busy_deferred", busy, 1'b1);
    tick();
    chk("t3_second_en", wr_en_0, 1'b1);
    chk("t3_second_addr", wr_addr_0, 2);
    chk("t3_second_data", wr_wide_0, db);
    chk("t3_busy_drop", busy, 1'b0);
    tick();
    chk("t3_quiet", wr_en_0, 1'b0);
    repeat (2) tick();

    // 4: six consecutive bank-0 collisions overflow a 4-deep FIFO
    set_mode(0, 0);
    for (int c = 0; c < 30; c++) begin
      idle_issue(); rand_data();
      if (c < 6) issue_b(0, 32 + c);
      if (c >= 17 && c <= 22) issue_a(0, 16 + c - 17);
      if (c >= 19 && c <= 28) begin
        chk("t4_wr_en", wr_en_0, 1'b1);
        chk("t4_wr_addr", wr_addr_0, seq4[c-19]);
      end
      if (c == 29) begin
        chk("t4_done", wr_en_0, 1'b0);
        chk("t4_ovf_set", defer_ovf, 1'b1);
        clr_status = 1;
      end
      tick();
    end
    idle_issue();
    chk("t4_ovf_clr", defer_ovf, 1'b0);
    repeat (2) tick();

    // 5a: NTT DIF then DIT back-to-back on lane A, both land
    for (int c = 0; c < 8; c++) begin
      idle_issue(); rand_data();
      if (c == 0) begin set_mode(0, 1); issue_a(0, 40); end
      if (c == 1) begin set_mode(0, 0); issue_a(0, 41); end
      if (c == 3) begin chk("t5_dit_en", wr_en_0, 1'b1); chk("t5_dit_addr", wr_addr_0, 41); end
      if (c == 5) begin chk("t5_dif_en", wr_en_0, 1'b1); chk("t5_dif_addr", wr_addr_0, 40); end
      tick();
    end
    idle_issue();
    chk("t5_no_clash", lane_clash, 1'b0);
    // 5b: equal exit cycles on lane A
    for (int c = 0; c < 8; c++) begin
      idle_issue(); rand_data();
      if (c == 0) begin set_mode(0, 1); issue_a(0, 50); end
      if (c == 3) begin set_mode(0, 0); issue_a(0, 51); end
      if (c == 5) begin
        chk("t5_clash_en", wr_en_0, 1'b1);
        chk("t5_clash_addr", wr_addr_0, 50);
        chk("t5_clash_flag", lane_clash, 1'b1);
      end
      if (c == 6) chk("t5_younger_gone", wr_en_0, 1'b0);
      if (c == 7) clr_status = 1;
      tick();
    end
    idle_issue();
    chk("t5_clash_clr", lane_clash, 1'b0);
    repeat (2) tick();

    // 6: reset with 3 tokens in flight and 2 deferred writes
    set_mode(0, 0);
    for (int c = 0; c < 20; c++) begin
      idle_issue(); rand_data();
      if (c < 2) issue_b(0, 60 + c);
      if (c >= 10 && c <= 12) issue_b(1, 70 + c - 10);
      if (c == 17 || c == 18) issue_a(0, 62 + c - 17);
      tick();
    end
    idle_issue();
    chk("t6_pre_busy", busy, 1'b1);
    chk("t6_pre_en", wr_en_0, 1'b1);
    chk("t6_pre_addr", wr_addr_0, 60);
    rst_n = 0;
    #1;
    chk("t6_rst_en_0", wr_en_0, 1'b0);
    chk("t6_rst_en_1", wr_en_1, 1'b0);
    chk("t6_rst_addr_0", wr_addr_0, 0);
    chk("t6_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1;
    wcount = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (wr_en_0 || wr_en_1) wcount++;
    end
    chk("t6_no_writes_after", wcount, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle_issue(); rand_data();
      set_mode($urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 99) < 35) issue_a($urandom_range(0, 1), $urandom_range(0, 4095));
      if ($urandom_range(0, 99) < 35) issue_b($urandom_range(0, 1), $urandom_range(0, 4095));
      clr_status = ($urandom_range(0, 99) < 3);
      tick();
    end
    idle_issue();
    repeat (40) tick();
    chk("drain_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
